vsc8541_smi_sequencer: RTL and testbench

Command queue and sequencer that sits directly upstream of `vsc8541_smi_mdio`. It accepts SMI read/write commands from the register block or an init ROM and buffers them in a FIFO. It issues them one at a time to the MDIO engine, waits for completion, and returns a per-command response so software no longer has to pulse enables by hand.

---
 rtl/vsc8541_smi_sequencer_pkg.sv | 12 +
 rtl/vsc8541_smi_sequencer_if.sv | 31 +++
 rtl/vsc8541_smi_sequencer_cmd_fifo.sv | 49 ++++
 rtl/vsc8541_smi_sequencer.sv | 108 ++++++++++
 tb/tb_vsc8541_smi_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vsc8541_smi_sequencer_pkg.sv
// vsc8541_smi_pkg: command struct, mode constants and sequencer state enum for the SMI command sequencer.
package vsc8541_smi_pkg;
   localparam logic SMI_MODE_READ  = 1'b0;
   localparam logic SMI_MODE_WRITE = 1'b1;
   typedef struct packed {
      logic [15:0] data;
      logic [4:0]  reg_addr;
      logic [4:0]  phy_addr;
      logic        mode;
   } smi_cmd_t;
   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ISSUE, ST_WAIT, ST_GAP} smi_seq_state_t;
endpackage

// File: rtl/vsc8541_smi_sequencer_if.sv
// vsc8541_smi_sequencer_if: command, response and MDIO-engine signals of the SMI sequencer.
interface vsc8541_smi_sequencer_if #(parameter int FIFO_DEPTH = 8);
   import vsc8541_smi_pkg::*;
   logic                        i_cmd_valid;
   logic                        o_cmd_ready;
   smi_cmd_t                    i_cmd;
   logic                        i_flush;
   logic                        o_mdio_en;
   logic                        o_mdio_mode;
   logic [4:0]                  o_mdio_phy_addr;
   logic [4:0]                  o_mdio_reg_addr;
   logic [15:0]                 o_mdio_data;
   logic                        i_mdio_dv;
   logic [15:0]                 i_mdio_data;
   logic                        o_rsp_valid;
   logic [15:0]                 o_rsp_data;
   logic                        o_rsp_is_read;
   logic                        o_rsp_timeout;
   logic                        o_busy;
   logic [$clog2(FIFO_DEPTH):0] o_level;
   modport slave (
      input  i_cmd_valid, i_cmd, i_flush, i_mdio_dv, i_mdio_data,
      output o_cmd_ready, o_mdio_en, o_mdio_mode, o_mdio_phy_addr, o_mdio_reg_addr, o_mdio_data,
             o_rsp_valid, o_rsp_data, o_rsp_is_read, o_rsp_timeout, o_busy, o_level
   );
   modport master (
      output i_cmd_valid, i_cmd, i_flush, i_mdio_dv, i_mdio_data,
      input  o_cmd_ready, o_mdio_en, o_mdio_mode, o_mdio_phy_addr, o_mdio_reg_addr, o_mdio_data,
             o_rsp_valid, o_rsp_data, o_rsp_is_read, o_rsp_timeout, o_busy, o_level
   );
endinterface

// File: rtl/vsc8541_smi_sequencer_cmd_fifo.sv
// vsc8541_smi_cmd_fifo: synchronous command FIFO with flush, registered full/empty and occupancy level.
module vsc8541_smi_cmd_fifo
   import vsc8541_smi_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  smi_cmd_t                din_i,
   input  logic                    pop_i,
   input  logic                    flush_i,
   output smi_cmd_t                dout_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  level_o
);
   localparam int AW = $clog2(DEPTH);
   smi_cmd_t    mem_q [DEPTH];
   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q;
   logic        full_q, empty_q, wr, rd;
   // Flush wins over push and pop: the write is dropped and the read pointer jumps to the write pointer.
   always_comb begin
      wr     = push_i & ~full_q & ~flush_i;
      rd     = pop_i & ~empty_q & ~flush_i;
      wptr_d = wptr_q + (AW+1)'(wr);
      rptr_d = flush_i ? wptr_q : rptr_q + (AW+1)'(rd);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= wptr_d - rptr_d;
         full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
         empty_q <= wptr_d == rptr_d;
      end
   always_ff @(posedge clk)
      if (wr) mem_q[wptr_q[AW-1:0]] <= din_i;
   assign dout_o  = mem_q[rptr_q[AW-1:0]];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign level_o = level_q;
endmodule

// File: rtl/vsc8541_smi_sequencer.sv
// vsc8541_smi_sequencer: queues SMI commands and issues them one at a time to the MDIO engine.
// Optional WAIT timeout enabled by defining SMI_SEQ_TIMEOUT_EN.
module vsc8541_smi_sequencer
   import vsc8541_smi_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_CYCLES = 100
`ifdef SMI_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 2**20
`endif
) (
   input logic                     clk,
   input logic                     i_reset_n,
   vsc8541_smi_sequencer_if.slave  bus
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef SMI_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
   localparam int CMAX  = GAP_CYCLES > TIMEOUT_CYCLES ? GAP_CYCLES : TIMEOUT_CYCLES;
`else
   localparam bit TO_EN = 1'b0;
   localparam int CMAX  = GAP_CYCLES;
`endif
   localparam int CW = $clog2(CMAX + 1);
   smi_seq_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   smi_cmd_t       cmd_q, cmd_d, head;
   logic           rsp_valid_q, rsp_valid_d, rsp_is_read_q, rsp_is_read_d, rsp_timeout_q, rsp_timeout_d;
   logic [15:0]    rsp_data_q, rsp_data_d;
   logic           pop, full, empty, timeout, done;
   logic [LW-1:0]  level;
   vsc8541_smi_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (i_reset_n),
      .push_i  (bus.i_cmd_valid),
      .din_i   (bus.i_cmd),
      .pop_i   (pop),
      .flush_i (bus.i_flush),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );
`ifdef SMI_SEQ_TIMEOUT_EN
   assign timeout = state_q == ST_WAIT && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clk or negedge i_reset_n)
      if (!i_reset_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         cmd_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_is_read_q <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cmd_q         <= cmd_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_is_read_q <= rsp_is_read_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_data_q    <= rsp_data_d;
      end
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE:  state_d = empty ? ST_IDLE : ST_LOAD;
         // A flush landing on the LOAD cycle discards the head, so nothing is issued.
         ST_LOAD: begin
            pop     = 1'b1;
            state_d = (bus.i_flush | empty) ? ST_IDLE : ST_ISSUE;
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  state_d = (bus.i_mdio_dv | timeout) ? ST_GAP : ST_WAIT;
         ST_GAP:   state_d = cnt_q == CW'(GAP_CYCLES - 1) ? ST_IDLE : ST_GAP;
         default:  state_d = ST_IDLE;
      endcase
      cnt_d         = (state_d == state_q && (state_q == ST_GAP || (TO_EN && state_q == ST_WAIT))) ?
                      cnt_q + CW'(1) : '0;
      cmd_d         = state_q == ST_LOAD ? head : cmd_q;
      done          = state_q == ST_WAIT && (bus.i_mdio_dv || timeout);
      rsp_valid_d   = done;
      rsp_is_read_d = done ? ~cmd_q.mode : rsp_is_read_q;
      rsp_timeout_d = done ? ~bus.i_mdio_dv : rsp_timeout_q;
      rsp_data_d    = !done ? rsp_data_q :
                      !bus.i_mdio_dv ? 16'hFFFF :
                      cmd_q.mode == SMI_MODE_WRITE ? 16'h0000 : bus.i_mdio_data;
   end
   always_comb begin
      bus.o_cmd_ready     = ~full;
      bus.o_mdio_en       = state_q == ST_ISSUE;
      bus.o_mdio_mode     = cmd_q.mode;
      bus.o_mdio_phy_addr = cmd_q.phy_addr;
      bus.o_mdio_reg_addr = cmd_q.reg_addr;
      bus.o_mdio_data     = cmd_q.data;
      bus.o_rsp_valid     = rsp_valid_q;
      bus.o_rsp_data      = rsp_data_q;
      bus.o_rsp_is_read   = rsp_is_read_q;
      bus.o_rsp_timeout   = rsp_timeout_q;
      bus.o_busy          = state_q != ST_IDLE || !empty;
      bus.o_level         = level;
   end
endmodule

// File: tb/tb_vsc8541_smi_sequencer.sv
// tb_vsc8541_smi_sequencer: scoreboard bench for the SMI command sequencer (timeout case under SMI_SEQ_TIMEOUT_EN).
module tb_vsc8541_smi_sequencer;
   import vsc8541_smi_pkg::*;
   localparam int GAP = 10;
   typedef struct packed {
      logic [15:0] data;
      logic        is_read;
      logic        to;
   } rsp_t;
   logic     clk = 1'b0;
   logic     rst_n = 1'b0;
   rsp_t     exp_q [$];
   smi_cmd_t cq [$];
   int       total = 0;
   int       bad = 0;
   always #5 clk = ~clk;
   vsc8541_smi_sequencer_if #(.FIFO_DEPTH(8)) bus ();
   vsc8541_smi_sequencer #(
      .FIFO_DEPTH (8),
      .GAP_CYCLES (GAP)
`ifdef SMI_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (50)
`endif
   ) dut (
      .clk       (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );
   function automatic logic [15:0] rd_fn(input logic [4:0] p, input logic [4:0] r);
      return (p == 5'd1 && r == 5'd2) ? 16'h0007 : {p, r, 6'h15};
   endfunction
   function automatic rsp_t exp_of(input smi_cmd_t c);
      return '{data: c.mode ? 16'h0000 : rd_fn(c.phy_addr, c.reg_addr), is_read: ~c.mode, to: 1'b0};
   endfunction
   function automatic smi_cmd_t cur_cmd();
      return '{data: bus.o_mdio_data, reg_addr: bus.o_mdio_reg_addr, phy_addr: bus.o_mdio_phy_addr, mode: bus.o_mdio_mode};
   endfunction
   function automatic rsp_t cur_rsp();
      return '{data: bus.o_rsp_data, is_read: bus.o_rsp_is_read, to: bus.o_rsp_timeout};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input smi_cmd_t c);
      bus.i_cmd       = c;
      bus.i_cmd_valid = 1'b1;
      tick();
      bus.i_cmd_valid = 1'b0;
   endtask
   task automatic expect_cmd(input smi_cmd_t c);
      cq.push_back(c);
      exp_q.push_back(exp_of(c));
   endtask
   task automatic wait_en(input int max, output int n);
      n = 0;
      while (!bus.o_mdio_en && n < max) begin
         tick();
         n++;
      end
   endtask
   task automatic wait_idle();
      for (int k = 0; k < GAP + 20 && bus.o_busy; k++) tick();
   endtask
   task automatic engine_done(input smi_cmd_t c);
      bus.i_mdio_dv   = 1'b1;
      bus.i_mdio_data = c.mode ? 16'hDEAD : rd_fn(c.phy_addr, c.reg_addr);
      tick();
      bus.i_mdio_dv   = 1'b0;
      bus.i_mdio_data = 16'h0;
   endtask

   task automatic test_reset();
      logic [57:0] z;
      #12;
      z = {bus.o_mdio_en, cur_cmd(), bus.o_rsp_valid, cur_rsp(), bus.o_busy, bus.o_level};
      total++;
      if (z !== '0) begin bad++; $display("FAIL reset_zero got=%h want=0", z); end
      total++;
      if (bus.o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.o_cmd_ready); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      total++;
      if (bus.o_mdio_en !== 1'b0) begin bad++; $display("FAIL reset_after_en got=%b want=0", bus.o_mdio_en); end
      engine_done('0);
      total++;
      if (bus.o_rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_dv_ignored got=%b want=0", bus.o_rsp_valid); end
   endtask

   task automatic test_write();
      smi_cmd_t c = '{data: 16'hBEEF, reg_addr: 5'd0, phy_addr: 5'd1, mode: SMI_MODE_WRITE};
      smi_cmd_t e;
      rsp_t     r;
      expect_cmd(c);
      push(c);
      total++;
      if (bus.o_level !== 4'd1 || bus.o_mdio_en !== 1'b0)
         begin bad++; $display("FAIL wr_level got=%0d/%b want=1/0", bus.o_level, bus.o_mdio_en); end
      tick();
      total++;
      if (bus.o_mdio_en !== 1'b0) begin bad++; $display("FAIL wr_en_n1 got=%b want=0", bus.o_mdio_en); end
      tick();
      e = cq.pop_front();
      total++;
      if (bus.o_mdio_en !== 1'b1 || cur_cmd() !== e)
         begin bad++; $display("FAIL wr_issue_n2 got=%b/%h want=1/%h", bus.o_mdio_en, cur_cmd(), e); end
      tick();
      total++;
      if (bus.o_mdio_en !== 1'b0 || bus.o_busy !== 1'b1)
         begin bad++; $display("FAIL wr_en_pulse got=%b/%b want=0/1", bus.o_mdio_en, bus.o_busy); end
      engine_done(e);
      r = exp_q.pop_front();
      total++;
      if (bus.o_rsp_valid !== 1'b1 || cur_rsp() !== r)
         begin bad++; $display("FAIL wr_rsp got=%b/%h want=1/%h", bus.o_rsp_valid, cur_rsp(), r); end
      tick();
      total++;
      if (bus.o_rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_pulse got=%b want=0", bus.o_rsp_valid); end
      wait_idle();
   endtask

   task automatic test_read();
      smi_cmd_t c = '{data: 16'h0, reg_addr: 5'd2, phy_addr: 5'd1, mode: SMI_MODE_READ};
      smi_cmd_t e;
      rsp_t     r;
      int       n;
      expect_cmd(c);
      push(c);
      wait_en(10, n);
      e = cq.pop_front();
      total++;
      if (bus.o_mdio_en !== 1'b1 || cur_cmd() !== e)
         begin bad++; $display("FAIL rd_issue got=%b/%h want=1/%h", bus.o_mdio_en, cur_cmd(), e); end
      tick();
      engine_done(e);
      r = exp_q.pop_front();
      total++;
      if (bus.o_rsp_valid !== 1'b1 || cur_rsp() !== r)
         begin bad++; $display("FAIL rd_rsp got=%b/%h want=1/%h", bus.o_rsp_valid, cur_rsp(), r); end
      wait_idle();
   endtask

   task automatic test_fill();
      smi_cmd_t a = '{data: 16'hA000, reg_addr: 5'd9, phy_addr: 5'd2, mode: SMI_MODE_WRITE};
      smi_cmd_t c, e;
      rsp_t     r;
      int       n;
      expect_cmd(a);
      push(a);
      wait_en(10, n);
      e = cq.pop_front();
      total++;
      if (bus.o_mdio_en !== 1'b1 || cur_cmd() !== e)
         begin bad++; $display("FAIL fill_first got=%b/%h want=1/%h", bus.o_mdio_en, cur_cmd(), e); end
      for (int i = 0; i < 9; i++) begin
         c = '{data: 16'h1000 + 16'(i), reg_addr: 5'(i), phy_addr: 5'(i + 3), mode: i[0]};
         if (i < 8) expect_cmd(c);
         push(c);
         if (i == 7) begin
            total++;
            if (bus.o_cmd_ready !== 1'b0 || bus.o_level !== 4'd8)
               begin bad++; $display("FAIL fill_full got=%b/%0d want=0/8", bus.o_cmd_ready, bus.o_level); end
         end
      end
      total++;
      if (bus.o_level !== 4'd8) begin bad++; $display("FAIL fill_drop got=%0d want=8", bus.o_level); end
      engine_done(e);
      r = exp_q.pop_front();
      total++;
      if (bus.o_rsp_valid !== 1'b1 || cur_rsp() !== r)
         begin bad++; $display("FAIL fill_rsp0 got=%b/%h want=1/%h", bus.o_rsp_valid, cur_rsp(), r); end
      for (int i = 0; i < 8; i++) begin
         wait_en(GAP + 20, n);
         e = cq.pop_front();
         total++;
         if (bus.o_mdio_en !== 1'b1 || cur_cmd() !== e || n < GAP + 2)
            begin bad++; $display("FAIL fill_issue%0d got=%b/%h/%0d want=1/%h/>=%0d", i, bus.o_mdio_en, cur_cmd(), n, e, GAP + 2); end
         tick();
         tick();
         engine_done(e);
         r = exp_q.pop_front();
         total++;
         if (bus.o_rsp_valid !== 1'b1 || cur_rsp() !== r)
            begin bad++; $display("FAIL fill_rsp%0d got=%b/%h want=1/%h", i + 1, bus.o_rsp_valid, cur_rsp(), r); end
      end
      wait_en(GAP + 10, n);
      total++;
      if (bus.o_mdio_en !== 1'b0 || bus.o_level !== 4'd0)
         begin bad++; $display("FAIL fill_extra got=%b/%0d want=0/0", bus.o_mdio_en, bus.o_level); end
      wait_idle();
   endtask

   task automatic test_flush();
      smi_cmd_t a = '{data: 16'h5A5A, reg_addr: 5'd3, phy_addr: 5'd4, mode: SMI_MODE_WRITE};
      smi_cmd_t e;
      rsp_t     r;
      int       n;
      logic     saw = 1'b0;
      expect_cmd(a);
      push(a);
      wait_en(10, n);
      e = cq.pop_front();
      total++;
      if (bus.o_mdio_en !== 1'b1 || cur_cmd() !== e)
         begin bad++; $display("FAIL fl_issue got=%b/%h want=1/%h", bus.o_mdio_en, cur_cmd(), e); end
      for (int i = 0; i < 3; i++) push('{data: 16'h7700 + 16'(i), reg_addr: 5'(i), phy_addr: 5'd7, mode: SMI_MODE_READ});
      total++;
      if (bus.o_level !== 4'd3) begin bad++; $display("FAIL fl_level3 got=%0d want=3", bus.o_level); end
      bus.i_cmd       = '{data: 16'hEEEE, reg_addr: 5'd1, phy_addr: 5'd1, mode: SMI_MODE_WRITE};
      bus.i_cmd_valid = 1'b1;
      bus.i_flush     = 1'b1;
      tick();
      bus.i_cmd_valid = 1'b0;
      bus.i_flush     = 1'b0;
      total++;
      if (bus.o_level !== 4'd0 || bus.o_cmd_ready !== 1'b1)
         begin bad++; $display("FAIL fl_level0 got=%0d/%b want=0/1", bus.o_level, bus.o_cmd_ready); end
      engine_done(e);
      r = exp_q.pop_front();
      total++;
      if (bus.o_rsp_valid !== 1'b1 || cur_rsp() !== r)
         begin bad++; $display("FAIL fl_rsp got=%b/%h want=1/%h", bus.o_rsp_valid, cur_rsp(), r); end
      for (int k = 0; k < GAP + 10; k++) begin
         tick();
         saw |= bus.o_mdio_en;
      end
      total++;
      if (saw !== 1'b0 || bus.o_busy !== 1'b0)
         begin bad++; $display("FAIL fl_no_issue got=%b/%b want=0/0", saw, bus.o_busy); end
   endtask

`ifdef SMI_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      smi_cmd_t c = '{data: 16'h0, reg_addr: 5'd6, phy_addr: 5'd5, mode: SMI_MODE_READ};
      smi_cmd_t e;
      rsp_t     r;
      int       n;
      cq.push_back(c);
      exp_q.push_back('{data: 16'hFFFF, is_read: 1'b1, to: 1'b1});
      push(c);
      wait_en(10, n);
      e = cq.pop_front();
      total++;
      if (bus.o_mdio_en !== 1'b1 || cur_cmd() !== e)
         begin bad++; $display("FAIL to_issue got=%b/%h want=1/%h", bus.o_mdio_en, cur_cmd(), e); end
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.o_rsp_valid && n < 200);
      r = exp_q.pop_front();
      total++;
      if (n != 51 || bus.o_rsp_valid !== 1'b1 || cur_rsp() !== r)
         begin bad++; $display("FAIL to_rsp got=%0d/%b/%h want=51/1/%h", n, bus.o_rsp_valid, cur_rsp(), r); end
      wait_idle();
   endtask
`endif

   task automatic test_reset_mid();
      smi_cmd_t    a = '{data: 16'hC0DE, reg_addr: 5'd4, phy_addr: 5'd3, mode: SMI_MODE_READ};
      smi_cmd_t    e;
      logic [57:0] z;
      int          n;
      cq.push_back(a);
      push(a);
      wait_en(10, n);
      e = cq.pop_front();
      total++;
      if (bus.o_mdio_en !== 1'b1 || cur_cmd() !== e)
         begin bad++; $display("FAIL rm_issue got=%b/%h want=1/%h", bus.o_mdio_en, cur_cmd(), e); end
      push('{data: 16'h1111, reg_addr: 5'd1, phy_addr: 5'd1, mode: SMI_MODE_WRITE});
      #2 rst_n = 1'b0;
      #1;
      z = {bus.o_mdio_en, cur_cmd(), bus.o_rsp_valid, cur_rsp(), bus.o_busy, bus.o_level};
      total++;
      if (z !== '0 || bus.o_cmd_ready !== 1'b1)
         begin bad++; $display("FAIL rm_async got=%h/%b want=0/1", z, bus.o_cmd_ready); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (bus.o_mdio_en !== 1'b0) begin bad++; $display("FAIL rm_en_after got=%b want=0", bus.o_mdio_en); end
      engine_done(a);
      total++;
      if (bus.o_rsp_valid !== 1'b0 || bus.o_busy !== 1'b0)
         begin bad++; $display("FAIL rm_late_dv got=%b/%b want=0/0", bus.o_rsp_valid, bus.o_busy); end
      cq.delete();
      exp_q.delete();
   endtask

   initial begin
      bus.i_cmd_valid = 1'b0;
      bus.i_cmd       = '0;
      bus.i_flush     = 1'b0;
      bus.i_mdio_dv   = 1'b0;
      bus.i_mdio_data = '0;
      test_reset();
      test_write();
      test_read();
      test_fill();
      test_flush();
`ifdef SMI_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
